// File: rtl/tt_dpll_pkg.sv
// Shared types and constants for the tt_dpll scan-chain control path.
// Provides the scan sequencer state enum and the default chain length.
package tt_dpll_pkg;

  localparam int DPLL_SCAN_LEN = 16;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    VERIFY,
    WAIT_LOCK,
    DONE
  } scan_state_t;

endpackage

// File: rtl/tt_dpll_scan_shifter.sv
// Cfg word / readback registers and bit counter for the scan sequencer.
// Ports: i_load latches i_cfg, i_step advances a bit, i_capture stores
// i_scan_out into readback; o_cfg_bit is the current bit, o_last_bit ends a pass.
module tt_dpll_scan_shifter
  import tt_dpll_pkg::*;
#(
  parameter int CHAIN_LEN = DPLL_SCAN_LEN
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic [CHAIN_LEN-1:0] i_cfg,
  input  logic                 i_step,
  input  logic                 i_capture,
  input  logic                 i_scan_out,
  output logic                 o_cfg_bit,
  output logic                 o_last_bit,
  output logic [CHAIN_LEN-1:0] o_readback
);

  localparam int BW = $clog2(CHAIN_LEN);

  logic [CHAIN_LEN-1:0] r_cfg;
  logic [CHAIN_LEN-1:0] r_rb;
  logic [BW-1:0]        r_bit;
  logic                 w_last;

  assign w_last     = (r_bit == BW'(CHAIN_LEN - 1));
  assign o_last_bit = w_last;
  assign o_cfg_bit  = r_cfg[r_bit];
  assign o_readback = r_rb;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cfg <= '0;
      r_rb  <= '0;
      r_bit <= '0;
    end else if (i_load) begin
      r_cfg <= i_cfg;
      r_bit <= '0;
    end else if (i_step) begin
      if (i_capture) begin
        r_rb[r_bit] <= i_scan_out;
      end
      // Wrap explicitly so non-power-of-two chains restart at 0.
      r_bit <= w_last ? '0 : r_bit + BW'(1);
    end
  end

endmodule

// File: rtl/tt_dpll_scan_ctrl.sv
// Scan-chain configuration sequencer for tt_dpll: shift, verify, wait lock.
// Ports: start/verify/cfg in, scan_en/scan_in/scan_out chain, busy/done/readback/errors out.
module tt_dpll_scan_ctrl
  import tt_dpll_pkg::*;
#(
  parameter int CHAIN_LEN    = DPLL_SCAN_LEN,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_verify,
  input  logic [CHAIN_LEN-1:0] i_cfg_data,
  input  logic                 i_scan_out,
  input  logic                 i_locked,
  output logic                 o_scan_en,
  output logic                 o_scan_in,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CHAIN_LEN-1:0] o_readback,
  output logic                 o_err_verify,
  output logic                 o_err_timeout
);

  localparam int LW = $clog2(LOCK_TIMEOUT);

  scan_state_t r_state;
  scan_state_t w_next;
  logic [LW-1:0] r_lock_cnt;
  logic          r_verify;
  logic          r_err_v;
  logic          r_err_t;
  logic          w_start;
  logic          w_step;
  logic          w_cfg_bit;
  logic          w_last;
  logic          w_tmo;

  assign w_start = (r_state == IDLE) && i_start;
  assign w_step  = (r_state == SHIFT) || (r_state == VERIFY);
  assign w_tmo   = (r_lock_cnt == LW'(LOCK_TIMEOUT - 1));

  tt_dpll_scan_shifter #(
    .CHAIN_LEN(CHAIN_LEN)
  ) u_shifter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_start),
    .i_cfg      (i_cfg_data),
    .i_step     (w_step),
    .i_capture  (r_state == SHIFT),
    .i_scan_out (i_scan_out),
    .o_cfg_bit  (w_cfg_bit),
    .o_last_bit (w_last),
    .o_readback (o_readback)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (i_start) w_next = SHIFT;
      SHIFT:     if (w_last) w_next = r_verify ? VERIFY : WAIT_LOCK;
      VERIFY:    if (w_last) w_next = WAIT_LOCK;
      WAIT_LOCK: if (i_locked || w_tmo) w_next = DONE;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy    = 1'b0;
    o_scan_en = 1'b0;
    o_done    = 1'b0;
    unique case (r_state)
      SHIFT, VERIFY: begin
        o_busy    = 1'b1;
        o_scan_en = 1'b1;
      end
      WAIT_LOCK: o_busy = 1'b1;
      DONE:      o_done = 1'b1;
      default:   o_busy = 1'b0;
    endcase
  end

  // Scan data is forced low outside shifting so it idles at its reset value.
  assign o_scan_in     = o_scan_en & w_cfg_bit;
  assign o_err_verify  = r_err_v;
  assign o_err_timeout = r_err_t;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lock_cnt <= '0;
      r_verify   <= 1'b0;
      r_err_v    <= 1'b0;
      r_err_t    <= 1'b0;
    end else begin
      if (r_state != WAIT_LOCK) begin
        r_lock_cnt <= '0;
      end else if (!w_tmo) begin
        r_lock_cnt <= r_lock_cnt + LW'(1);
      end
      if (w_start) begin
        r_verify <= i_verify;
        r_err_v  <= 1'b0;
        r_err_t  <= 1'b0;
      end else begin
        if ((r_state == VERIFY) && (i_scan_out != w_cfg_bit)) begin
          r_err_v <= 1'b1;
        end
        // Lock wins over timeout on the same cycle.
        if ((r_state == WAIT_LOCK) && !i_locked && w_tmo) begin
          r_err_t <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tt_dpll_scan_ctrl.sv
// Directed bench for tt_dpll_scan_ctrl with a behavioural scan chain.
// Expected scan bits are queued at start and popped each shift cycle.
module tb_tt_dpll_scan_ctrl;

  localparam int CL = 16;
  localparam int LT = 64;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic          i_verify;
  logic [CL-1:0] i_cfg_data;
  logic          i_scan_out;
  logic          i_locked;
  logic          o_scan_en;
  logic          o_scan_in;
  logic          o_busy;
  logic          o_done;
  logic [CL-1:0] o_readback;
  logic          o_err_verify;
  logic          o_err_timeout;

  logic [CL-1:0] chain = '0;
  logic          flip = 1'b0;
  int            checks = 0;
  int            errors = 0;
  bit            q[$];

  tt_dpll_scan_ctrl #(
    .CHAIN_LEN(CL),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_verify      (i_verify),
    .i_cfg_data    (i_cfg_data),
    .i_scan_out    (i_scan_out),
    .i_locked      (i_locked),
    .o_scan_en     (o_scan_en),
    .o_scan_in     (o_scan_in),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_readback    (o_readback),
    .o_err_verify  (o_err_verify),
    .o_err_timeout (o_err_timeout)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_scan_en) chain <= {o_scan_in, chain[CL-1:1]};
  end

  assign i_scan_out = chain[0] ^ flip;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_load(input logic [CL-1:0] cfg, input logic ver,
                          input int lock_from, input int lock_to,
                          input bit do_flip, input bit glitch,
                          input logic [CL-1:0] exp_rb, input int exp_lat,
                          input logic exp_ev, input logic exp_et);
    int done_at;
    int nshift;
    bit b;
    nshift = ver ? 2 * CL : CL;
    q.delete();
    for (int i = 0; i < CL; i++) q.push_back(cfg[i]);
    if (ver) for (int i = 0; i < CL; i++) q.push_back(cfg[i]);
    i_cfg_data = cfg;
    i_verify   = ver;
    i_start    = 1'b1;
    tick();
    i_start    = 1'b0;
    i_verify   = 1'b0;
    i_cfg_data = '0;
    chk("busy_after_start", o_busy, 1);
    chk("err_v_cleared", o_err_verify, 0);
    chk("err_t_cleared", o_err_timeout, 0);
    done_at = 0;
    for (int n = 1; n <= 200 && done_at == 0; n++) begin
      if (n <= nshift) begin
        b = q.pop_front();
        chk("scan_en_shift", o_scan_en, 1);
        chk("scan_in", o_scan_in, b);
      end else begin
        chk("scan_en_wait", o_scan_en, 0);
      end
      i_locked = (n >= lock_from) && (n <= lock_to);
      flip     = do_flip && ver && (n == CL + 8);
      if (glitch && n == 5) begin
        i_start    = 1'b1;
        i_cfg_data = '1;
      end else begin
        i_start    = 1'b0;
        i_cfg_data = '0;
      end
      tick();
      if (o_done) done_at = n;
    end
    flip     = 1'b0;
    i_locked = 1'b0;
    i_start  = 1'b0;
    chk("latency", done_at + 1, exp_lat);
    chk("readback", o_readback, exp_rb);
    chk("err_verify", o_err_verify, exp_ev);
    chk("err_timeout", o_err_timeout, exp_et);
    chk("chain_contents", chain, cfg);
    chk("busy_at_done", o_busy, 0);
    tick();
    chk("done_one_cycle", o_done, 0);
    chk("idle_busy", o_busy, 0);
  endtask

  initial begin
    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_verify   = 1'b0;
    i_cfg_data = '0;
    i_locked   = 1'b0;
    tick();
    tick();
    chk("rst_scan_en", o_scan_en, 0);
    chk("rst_scan_in", o_scan_in, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_readback", o_readback, 0);
    chk("rst_err_v", o_err_verify, 0);
    chk("rst_err_t", o_err_timeout, 0);
    i_rst = 1'b0;
    tick();

    // basic load, lock raised 5 cycles into WAIT_LOCK
    run_load(16'hA5C3, 1'b0, 22, 10000, 1'b0, 1'b0, 16'h0000, 23, 1'b0, 1'b0);
    // reload with verify, already locked
    run_load(16'h1234, 1'b1, 0, 10000, 1'b0, 1'b0, 16'hA5C3, 2*CL+2, 1'b0, 1'b0);
    // verify mismatch on bit 7
    run_load(16'h5A5A, 1'b1, 0, 10000, 1'b1, 1'b0, 16'h1234, 2*CL+2, 1'b1, 1'b0);
    // lock never arrives
    run_load(16'h0F0F, 1'b0, 10000, 10000, 1'b0, 1'b0, 16'h5A5A, CL+1+LT, 1'b0, 1'b1);
    // lock on the timeout cycle, plus ignored start during SHIFT
    run_load(16'h3C3C, 1'b0, CL+LT, CL+LT, 1'b0, 1'b1, 16'h0F0F, CL+1+LT, 1'b0, 1'b0);

    // reset in the middle of SHIFT
    i_cfg_data = 16'hFFFF;
    i_start    = 1'b1;
    tick();
    i_start    = 1'b0;
    repeat (7) tick();
    chk("pre_rst_scan_en", o_scan_en, 1);
    i_rst = 1'b1;
    tick();
    chk("mid_rst_scan_en", o_scan_en, 0);
    chk("mid_rst_scan_in", o_scan_in, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_done", o_done, 0);
    chk("mid_rst_readback", o_readback, 0);
    chk("mid_rst_err_v", o_err_verify, 0);
    chk("mid_rst_err_t", o_err_timeout, 0);
    i_rst = 1'b0;
    tick();
    chk("post_rst_idle", o_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_dpll_scan_ctrl.md
# tt_dpll_scan_ctrl

Configuration sequencer for the `tt_dpll` scan chain. It accepts a configuration word through a start/busy/done handshake and serially shifts the word into the DPLL over scan enable and scan data. It can optionally run a second verify pass that reads the chain back, then waits for the DPLL lock indication within a bounded timeout. It sits beside `tt_dpll` inside the top wrapper and replaces direct pin control of the scan chain.

## Interface
- `CHAIN_LEN`, 16, number of scan flops in the DPLL chain (≥ 2).
- `LOCK_TIMEOUT`, 1024, maximum cycles spent in WAIT_LOCK (≥ 2).
- `i_clk`  in  1  system clock; the DPLL scan chain shifts on the same edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  request a load; sampled only in IDLE.
- `i_verify`  in  1  enable the verify pass; latched with `i_start`.
- `i_cfg_data`  in  CHAIN_LEN  word to load; latched with `i_start`.
- `i_scan_out`  in  1  last flop of the DPLL chain.
- `i_locked`  in  1  DPLL lock flag, synchronous to `i_clk` (synchronized upstream).
- `o_scan_en`  out  1  chain shifts at every edge where this is 1.
- `o_scan_in`  out  1  serial data into the chain.
- `o_busy`  out  1  high in SHIFT, VERIFY and WAIT_LOCK.
- `o_done`  out  1  one-cycle completion pulse.
- `o_readback`  out  CHAIN_LEN  previous chain contents captured during SHIFT.
- `o_err_verify`  out  1  verify mismatch sticky flag; cleared on the next accepted start.
- `o_err_timeout`  out  1  lock timeout sticky flag; cleared on the next accepted start.

## Operation
- **States:** IDLE, SHIFT, VERIFY, WAIT_LOCK, DONE.
- **IDLE:**
  - If `i_start`=1, latch `i_cfg_data`/`i_verify`, clear both error flags and the bit counter, and go to SHIFT.
  - Otherwise stay in IDLE.
  - `i_start` is ignored in every other state.
- **SHIFT:**
  - `o_scan_en`=1 and `o_scan_in` = cfg[bit], LSB first.
  - At each edge, capture `i_scan_out` into readback[bit]. This is the bit falling out of the chain, i.e. the old contents in the same bit order.
  - After bit CHAIN_LEN-1, go to VERIFY if verify was latched, else go to WAIT_LOCK.
- **VERIFY:**
  - Reshift the same cfg word LSB first, which restores the chain.
  - Compare `i_scan_out` with cfg[bit]. Any mismatch sets `o_err_verify`.
  - After CHAIN_LEN bits, go to WAIT_LOCK.
  - A failed verify still proceeds to WAIT_LOCK.
- **WAIT_LOCK:**
  - `o_scan_en`=0 and the lock counter increments every cycle.
  - If `i_locked`=1, go to DONE.
  - Else, if the counter reaches LOCK_TIMEOUT-1, set `o_err_timeout` and go to DONE.
  - Lock wins over timeout in the same cycle.
- **DONE:** `o_done`=1 for exactly one cycle, then return to IDLE.
- **Bit counter:** $clog2(CHAIN_LEN) bits, wraps to 0 at the state change. **Lock counter:** $clog2(LOCK_TIMEOUT) bits, saturating.
- **Reset in any state:**
  - At the reset edge, go to IDLE with `o_scan_en`=0 from the next cycle.
  - All outputs and flags return to reset values.
  - Chain contents are then undefined; software must reload.

## Timing
- **Reset values:** `o_scan_en`=0, `o_scan_in`=0, `o_busy`=0, `o_done`=0, `o_readback`=0, both error flags 0.
- **Outputs are registered.** With `i_start` sampled at edge 0:
  - `o_busy` and `o_scan_en` rise after edge 0.
  - Shifting occurs at edges 1..CHAIN_LEN.
  - Verify, if enabled, occurs at edges CHAIN_LEN+1..2·CHAIN_LEN.
  - WAIT_LOCK begins on the next cycle.
- **Minimum latency to `o_done`:**
  - No verify, already locked: CHAIN_LEN+2 cycles.
  - With verify: 2·CHAIN_LEN+2 cycles.
- **Output stability:** `o_readback` is stable from SHIFT exit until the next accepted start. The error flags are valid when `o_done` is high.
- **Back-to-back loads:** `i_start` held high restarts one cycle after DONE (IDLE sampling).

## Structure
- **Shared package `tt_dpll_pkg`:**
  - Holds the `scan_state_t` enum (IDLE, SHIFT, VERIFY, WAIT_LOCK, DONE).
  - Holds `DPLL_SCAN_LEN`, the default chain length used by both `tt_dpll` and this block.
- **Sub-module `tt_dpll_scan_shifter`:** the cfg/readback shift registers plus the bit counter, with a `last_bit` flag output. The FSM, lock counter and error flags stay in `tt_dpll_scan_ctrl`.

## Test plan
- **Basic load:** reset, then start with cfg=0xA5C3, verify=0, behavioural chain model preloaded with 0.
  - `o_scan_in` = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - `o_readback`=0x0000.
  - `i_locked` raised 5 cycles into WAIT_LOCK → `o_done` at cycle 23 after start, no errors.
- **Reload with verify:** follow-up start with cfg=0x1234, verify=1 → `o_readback`=0xA5C3, `o_err_verify`=0, chain holds 0x1234, `o_done` 2·16+2 cycles after start when already locked.
- **Verify mismatch:** model flips bit 7 during VERIFY → `o_err_verify`=1 at `o_done`, flag cleared by the next start.
- **Lock timeout:** LOCK_TIMEOUT=64, `i_locked` held 0 → `o_err_timeout`=1 and `o_done` pulse after 64 WAIT_LOCK cycles. `i_locked` rising on the timeout cycle → no error.
- **Start while busy / reset mid-shift:**
  - `i_start` pulsed during SHIFT is ignored, with no change to the shifted bits.
  - `i_rst` at bit 7 → `o_scan_en`=0 and `o_busy`=0 the next cycle, all outputs at reset values.
